// File: rtl/cfg_reg_pkg.sv
// cfg_reg_pkg: shared access modes, defaults and ADC register indices for the config register file
package cfg_reg_pkg;
    typedef enum logic [1:0] {MODE_RW, MODE_RO, MODE_STICKY} reg_mode_e;
    localparam logic [31:0] DEFAULT_ILLEGAL_RD_VALUE = 32'hBAD0BAD0;
    localparam int INIT_TRIG_NUM  = 0;
    localparam int NEXT_TRIG_NUM  = 1;
    localparam int BUFFER_SIZE    = 2;
    localparam int CHANNEL_NUM    = 3;
    localparam int POST_TRIG_SIZE = 4;
endpackage

// File: rtl/cfg_reg_cell.sv
// cfg_reg_cell: one register with read/write, read-only or sticky W1C behaviour
module cfg_reg_cell
    import cfg_reg_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter reg_mode_e MODE       = MODE_RW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] set,
    input  logic [DATA_WIDTH-1:0] ro_data,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] rd_value
);
    logic [DATA_WIDTH-1:0] q_next;
    // sticky: set is applied after clear so a concurrent set wins
    always_comb q_next = MODE == MODE_RO ? q :
                         MODE == MODE_STICKY ? ((q & ~(wr ? wdata : '0)) | set) :
                         (wr ? wdata : q);
    assign rd_value = MODE == MODE_RO ? ro_data : q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else q <= q_next;
    end
endmodule

// File: rtl/cfg_register_file.sv
// cfg_register_file: parametrised control/status register bank with auto-increment select and error flag
module cfg_register_file
    import cfg_reg_pkg::*;
#(
    parameter int                      NUM_REGS         = 16,
    parameter int                      DATA_WIDTH       = 32,
    parameter logic [NUM_REGS-1:0]     RO_MASK          = NUM_REGS'(16'h0002),
    parameter logic [NUM_REGS-1:0]     STICKY_MASK      = '0,
    parameter bit                      AUTO_INC         = 1'b1,
    parameter logic [DATA_WIDTH-1:0]   ILLEGAL_RD_VALUE = DATA_WIDTH'(DEFAULT_ILLEGAL_RD_VALUE)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DATA_WIDTH-1:0]          rx_data,
    input  logic                           reg_num_le,
    input  logic                           wr_en,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          tx_data,
    output logic                           rd_valid,
    output logic                           illegal_reg_num,
    output logic                           access_err,
    input  logic                           err_clr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic [NUM_REGS-1:0]            rd_strobe,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_set
);
    localparam int IW = $clog2(NUM_REGS);
    logic [DATA_WIDTH-1:0] reg_num, reg_num_next;
    logic [DATA_WIDTH-1:0] rd_vals [NUM_REGS];
    logic [IW-1:0]         idx;
    logic [NUM_REGS-1:0]   wr_dec, rd_dec;
    logic                  legal_acc;
    assign idx             = reg_num[IW-1:0];
    assign illegal_reg_num = reg_num >= DATA_WIDTH'(NUM_REGS);
    assign legal_acc       = (rd_en || wr_en) && !illegal_reg_num;
    assign wr_dec          = (wr_en && !illegal_reg_num) ? NUM_REGS'(1) << idx : '0;
    assign rd_dec          = (rd_en && !illegal_reg_num) ? NUM_REGS'(1) << idx : '0;
    always_comb reg_num_next = reg_num_le ? rx_data :
                               (AUTO_INC && legal_acc) ?
                               (idx == IW'(NUM_REGS - 1) ? '0 : reg_num + DATA_WIDTH'(1)) :
                               reg_num;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        // read-only takes precedence should the masks ever overlap
        localparam reg_mode_e M = RO_MASK[i] ? MODE_RO : STICKY_MASK[i] ? MODE_STICKY : MODE_RW;
        cfg_reg_cell #(.DATA_WIDTH(DATA_WIDTH), .MODE(M)) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr_dec[i]),
            .wdata    (rx_data),
            .set      (status_set[i*DATA_WIDTH +: DATA_WIDTH]),
            .ro_data  (ro_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .q        (reg_q[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_value (rd_vals[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_num    <= '0;
            tx_data    <= '0;
            rd_valid   <= 1'b0;
            wr_strobe  <= '0;
            rd_strobe  <= '0;
            access_err <= 1'b0;
        end else begin
            reg_num    <= reg_num_next;
            tx_data    <= rd_en ? (illegal_reg_num ? ILLEGAL_RD_VALUE : rd_vals[idx]) : tx_data;
            rd_valid   <= rd_en;
            wr_strobe  <= wr_dec;
            rd_strobe  <= rd_dec;
            access_err <= ((rd_en || wr_en) && illegal_reg_num) || (access_err && !err_clr);
        end
    end
endmodule

// File: tb/tb_cfg_register_file.sv
// tb_cfg_register_file: directed and randomized checks against a behavioural register-file model
module tb_cfg_register_file;
    localparam int N = 16;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  rx_data = '0;
    logic         reg_num_le = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [31:0]  tx_data;
    logic         rd_valid, illegal_reg_num, access_err;
    logic [N*32-1:0] reg_q, ro_data = '0, status_set = '0;
    logic [N-1:0] wr_strobe, rd_strobe;
    int checks = 0, errors = 0;

    logic [31:0] m_regs [N];
    logic [31:0] m_rn, m_tx;
    logic        m_rv, m_err;
    logic [N-1:0] m_wrs, m_rds;

    cfg_register_file #(.NUM_REGS(N), .DATA_WIDTH(32), .RO_MASK(16'h0002),
                        .STICKY_MASK(16'h0020), .AUTO_INC(1'b1),
                        .ILLEGAL_RD_VALUE(32'hBAD0BAD0)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .reg_num_le(reg_num_le),
        .wr_en(wr_en), .rd_en(rd_en), .tx_data(tx_data), .rd_valid(rd_valid),
        .illegal_reg_num(illegal_reg_num), .access_err(access_err), .err_clr(err_clr),
        .reg_q(reg_q), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .ro_data(ro_data), .status_set(status_set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N*32-1:0] obs, input logic [N*32-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*32-1:0] exp_q();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[i*32 +: 32] = m_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_rn = '0; m_tx = '0; m_rv = 1'b0; m_err = 1'b0; m_wrs = '0; m_rds = '0;
    endtask

    // register 1 is read-only, register 5 is sticky W1C, the rest are plain storage
    task automatic model(input logic le, input logic [31:0] rx, input logic w, input logic r, input logic c);
        bit legal;
        int n;
        legal = m_rn < N;
        n = legal ? int'(m_rn) : 0;
        m_wrs = '0; m_rds = '0; m_rv = r;
        if (r) begin
            if (!legal) m_tx = 32'hBAD0BAD0;
            else if (n == 1) m_tx = ro_data[32 +: 32];
            else m_tx = m_regs[n];
        end
        for (int i = 0; i < N; i++) begin
            if (i == 5) m_regs[i] = (m_regs[i] & ~((w && legal && n == i) ? rx : 32'h0)) | status_set[i*32 +: 32];
            else if (i != 1 && w && legal && n == i) m_regs[i] = rx;
        end
        if (w && legal) m_wrs[n] = 1'b1;
        if (r && legal) m_rds[n] = 1'b1;
        if ((r || w) && !legal) m_err = 1'b1;
        else if (c) m_err = 1'b0;
        if (le) m_rn = rx;
        else if ((r || w) && legal) m_rn = (m_rn + 1) % N;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".tx_data"}, N*32'(tx_data), N*32'(m_tx));
        chk({tag, ".rd_valid"}, N*32'(rd_valid), N*32'(m_rv));
        chk({tag, ".wr_strobe"}, N*32'(wr_strobe), N*32'(m_wrs));
        chk({tag, ".rd_strobe"}, N*32'(rd_strobe), N*32'(m_rds));
        chk({tag, ".access_err"}, N*32'(access_err), N*32'(m_err));
        chk({tag, ".illegal"}, N*32'(illegal_reg_num), N*32'(m_rn >= N));
        chk({tag, ".reg_q"}, reg_q, exp_q());
    endtask

    task automatic step(input string tag, input logic le, input logic [31:0] rx,
                        input logic w, input logic r, input logic c);
        reg_num_le = le; rx_data = rx; wr_en = w; rd_en = r; err_clr = c;
        @(posedge clk); #1;
        model(le, rx, w, r, c);
        compare_all(tag);
        reg_num_le = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        compare_all("reset");
        #9 reset_n = 1'b1;
        step("idle", 0, 0, 0, 0, 0);

        step("wr_r0", 0, 32'h12345678, 1, 0, 0);
        chk("r0_after_wr", N*32'(reg_q[31:0]), N*32'(32'h12345678));
        step("ld0", 1, 0, 0, 0, 0);
        step("rd_r0", 0, 0, 0, 1, 0);
        chk("rd_r0_tx", N*32'(tx_data), N*32'(32'h12345678));
        chk("rd_r0_valid", N*32'(rd_valid), N*32'(1));

        step("ld14", 1, 14, 0, 0, 0);
        step("wr_a", 0, 32'hA, 1, 0, 0);
        chk("wrs14", N*32'(wr_strobe), N*32'(16'h4000));
        step("wr_b", 0, 32'hB, 1, 0, 0);
        chk("wrs15", N*32'(wr_strobe), N*32'(16'h8000));
        step("wr_c", 0, 32'hC, 1, 0, 0);
        chk("wrs0", N*32'(wr_strobe), N*32'(16'h0001));
        chk("r14", N*32'(reg_q[14*32 +: 32]), N*32'(32'hA));
        chk("r15", N*32'(reg_q[15*32 +: 32]), N*32'(32'hB));
        chk("r0_wrap", N*32'(reg_q[31:0]), N*32'(32'hC));

        ro_data[32 +: 32] = 32'h55;
        step("ld1", 1, 1, 0, 0, 0);
        step("wr_ro", 0, 32'hFF, 1, 0, 0);
        chk("ro_wrs1", N*32'(wr_strobe), N*32'(16'h0002));
        chk("ro_storage", N*32'(reg_q[32 +: 32]), N*32'(0));
        step("ld1b", 1, 1, 0, 0, 0);
        step("rd_ro", 0, 0, 0, 1, 0);
        chk("ro_tx", N*32'(tx_data), N*32'(32'h55));

        status_set[5*32 +: 32] = 32'h8;
        step("sset", 0, 0, 0, 0, 0);
        step("ld5", 1, 5, 0, 0, 0);
        step("wr5_set", 0, 32'h8, 1, 0, 0);
        chk("sticky_keep", N*32'(reg_q[5*32 +: 32]), N*32'(32'h8));
        status_set = '0;
        step("ld5b", 1, 5, 0, 0, 0);
        step("wr5_clr", 0, 32'h8, 1, 0, 0);
        chk("sticky_clr", N*32'(reg_q[5*32 +: 32]), N*32'(0));

        step("ld20", 1, 32'h20, 0, 0, 0);
        step("rd_ill", 0, 0, 0, 1, 0);
        chk("ill_flag", N*32'(illegal_reg_num), N*32'(1));
        chk("ill_tx", N*32'(tx_data), N*32'(32'hBAD0BAD0));
        chk("ill_err", N*32'(access_err), N*32'(1));
        step("wr_ill", 0, 32'h77, 1, 0, 0);
        chk("ill_nostrobe", N*32'(wr_strobe), N*32'(0));
        chk("ill_stays", N*32'(illegal_reg_num), N*32'(1));
        step("err_and_clr", 0, 0, 0, 1, 1);
        chk("err_wins", N*32'(access_err), N*32'(1));
        step("clr", 0, 0, 0, 0, 1);
        chk("err_cleared", N*32'(access_err), N*32'(0));

        step("ld2", 1, 2, 0, 0, 0);
        step("wr2", 0, 32'h11, 1, 0, 0);
        step("wr3", 0, 32'h33, 1, 0, 0);
        step("ld2b", 1, 2, 0, 0, 0);
        step("rdwr2", 0, 32'h99, 1, 1, 0);
        chk("rdwr_tx", N*32'(tx_data), N*32'(32'h11));
        chk("rdwr_r2", N*32'(reg_q[2*32 +: 32]), N*32'(32'h99));
        step("rd3", 0, 0, 0, 1, 0);
        chk("inc_once", N*32'(tx_data), N*32'(32'h33));

        step("rd_pend", 1, 4, 0, 1, 0);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("mid_reset");
        #2 reset_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            logic le, w, r, c;
            logic [31:0] rx;
            le = ($urandom_range(0, 7) == 0);
            w  = $urandom_range(0, 1);
            r  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 9) == 0);
            rx = le ? $urandom_range(0, 19) : $urandom;
            for (int i = 0; i < N; i++) ro_data[i*32 +: 32] = $urandom;
            status_set = '0;
            if ($urandom_range(0, 3) == 0) status_set[5*32 +: 32] = $urandom & $urandom;
            step("rand", le, rx, w, r, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_register_file.md
# cfg_register_file

Parametrised control/status register file between the Master-FPGA link decoder and the channel ADC acquisition logic. It generalises the fixed 16 × 32-bit register bank to NUM_REGS registers of DATA_WIDTH bits, with per-register access modes: read/write, read-only from fabric, and sticky write-1-to-clear status. It adds auto-incrementing register selection for burst access, a registered read-valid handshake and a sticky access-error flag.

## Interface
- NUM_REGS, 16: number of registers; legal range 2–256.
- DATA_WIDTH, 32: register and link data width.
- RO_MASK, 0x0002: bit i set means register i is read-only and reads ro_data slice i.
- STICKY_MASK, 0x0000: bit i set means register i is sticky status (W1C); it must not overlap RO_MASK.
- AUTO_INC, 1: 1 means the selected register number advances after each access.
- ILLEGAL_RD_VALUE, 0xBAD0BAD0: value returned for a read of a nonexistent register.
- clk  in  1  single clock, 125 MHz interconnect domain.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_WIDTH  write data, or register number when reg_num_le is high.
- reg_num_le  in  1  loads the register number from rx_data.
- wr_en  in  1  writes the selected register.
- rd_en  in  1  reads the selected register.
- tx_data  out  DATA_WIDTH  readback data.
- rd_valid  out  1  tx_data valid; one-cycle pulse.
- illegal_reg_num  out  1  selected register number ≥ NUM_REGS (combinational from reg_num).
- access_err  out  1  sticky: rd_en or wr_en occurred while illegal_reg_num was high.
- err_clr  in  1  clears access_err.
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- wr_strobe  out  NUM_REGS  one-cycle pulse per register write; it pulses for RO registers too.
- rd_strobe  out  NUM_REGS  one-cycle pulse per register read.
- ro_data  in  NUM_REGS*DATA_WIDTH  fabric values for RO registers; other slices are ignored.
- status_set  in  NUM_REGS*DATA_WIDTH  per-bit set inputs for sticky registers.

## Operation
- reg_num is a full DATA_WIDTH-bit register.
  - It loads from rx_data on reg_num_le.
  - Otherwise, when AUTO_INC=1 and a legal rd_en or wr_en occurs, it increments. At NUM_REGS-1 it wraps to 0.
  - An illegal reg_num never increments.
  - reg_num_le overrides any increment in the same cycle.
  - A rd_en/wr_en in the same cycle as reg_num_le uses the old reg_num.
- Write to an RW register: the register takes rx_data.
- Write to an RO register: storage is unchanged; wr_strobe still pulses.
- Sticky register, every cycle: reg ← (reg & ~clr) | set.
  - clr = rx_data when that register is written, else 0.
  - set = status_set slice.
  - Set wins over clear on the same bit.
- Read: tx_data ← selected value (RO registers return ro_data; RW and sticky registers return storage); rd_valid ← 1.
  - An illegal read returns ILLEGAL_RD_VALUE.
  - tx_data holds its value between reads.
- rd_en and wr_en together: the read returns the pre-write value, and reg_num increments once.
- Illegal write: no register changes and no strobe fires; access_err sets.
- access_err: a new error in the same cycle as err_clr wins, so access_err stays set.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied upstream): reg_num=0, all registers 0, tx_data=0, rd_valid=0, strobes=0, access_err=0.
- Write latency: a write in cycle N appears on reg_q in cycle N+1; wr_strobe is high in cycle N+1.
- Read latency: one cycle. tx_data, rd_valid and rd_strobe are valid in cycle N+1.
- Back-to-back accesses every cycle are supported with no stall.
- A sticky set asserted in cycle N is visible on reg_q in cycle N+1.
- Reset mid-burst: all state clears immediately; a pending rd_valid is dropped.

## Structure
- Shared package cfg_reg_pkg holds:
  - access-mode encodings (MODE_RW, MODE_RO, MODE_STICKY);
  - the default ILLEGAL_RD_VALUE;
  - the symbolic register indices used by the ADC controller (INIT_TRIG_NUM=0, NEXT_TRIG_NUM=1, BUFFER_SIZE=2, CHANNEL_NUM=3, POST_TRIG_SIZE=4).
- Sub-module cfg_reg_cell: one register with its mode, write/clear/set logic, instantiated NUM_REGS times in a generate loop.
- The top level holds reg_num, the readback mux and the error logic.

## Test plan
- Reset, then write 0x12345678 to R0, then read R0. Required: reg_q slice 0 = 0x12345678 in the cycle after the write; tx_data=0x12345678 with rd_valid one cycle after rd_en.
- AUTO_INC=1: load reg_num=14, then write 0xA, 0xB, 0xC on consecutive cycles. Required: R14=0xA, R15=0xB, R0=0xC (wrap); wr_strobe pulses bits 14, 15, 0 in order.
- RO_MASK bit 1, ro_data[1]=0x55: write 0xFF to R1, then read R1. Required: R1 storage is unchanged; tx_data=0x55; wr_strobe[1] pulses.
- STICKY_MASK bit 5: pulse status_set bit 3, then write 0x8 to R5 while status_set bit 3 is high. Required: R5=0x8 is retained. With set low, a second write of 0x8 gives R5=0.
- Load reg_num=0x20 and read. Required: illegal_reg_num=1; tx_data=0xBAD0BAD0; access_err=1; reg_num stays 0x20. Then err_clr. Required: access_err=0.
- Simultaneous rd_en and wr_en of 0x99 on R2 holding 0x11. Required: tx_data=0x11, R2=0x99, reg_num advances by exactly 1.
